// File: rtl/seg7_glyph_decoder_if.sv
// Output stream of the 7-segment glyph decoder: one decoded frame per valid/ready handshake,
// plus the overrun pulse raised when a stable frame arrives while one is still pending.
interface seg7_glyph_decoder_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    out_ready;
  logic                    out_valid;
  logic [4*NUM_DIGITS-1:0] out_code;
  logic [NUM_DIGITS-1:0]   out_blank;
  logic [NUM_DIGITS-1:0]   out_err;
  logic                    overrun;

  modport master (
    input  out_ready,
    output out_valid, out_code, out_blank, out_err, overrun
  );

  modport slave (
    output out_ready,
    input  out_valid, out_code, out_blank, out_err, overrun
  );
endinterface

// File: rtl/seg7_glyph_decoder.sv
// Debounces an active-low abcdefg segment bus and reports each new stable frame as hex codes.
// Optional SEG7_DEC_ERRCNT_EN adds a saturating 8-bit count of reported frames with bad glyphs.
module seg7_glyph_decoder #(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
`ifdef SEG7_DEC_ERRCNT_EN
  output logic [7:0]              err_count,
`endif
  seg7_glyph_decoder_if.master    out_if
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       blank;
    logic       err;
  } glyph_t;

  function automatic glyph_t decode_glyph(input logic [6:0] pat);
    glyph_t g;
    g = '{code: 4'h0, blank: 1'b0, err: 1'b0};
    case (pat)
      7'b0000001: g.code = 4'h0;
      7'b1001111: g.code = 4'h1;
      7'b0010010: g.code = 4'h2;
      7'b0000110: g.code = 4'h3;
      7'b1001100: g.code = 4'h4;
      7'b0100100: g.code = 4'h5;
      7'b0100000: g.code = 4'h6;
      7'b0001111: g.code = 4'h7;
      7'b0000000: g.code = 4'h8;
      7'b0000100: g.code = 4'h9;
      7'b0001000: g.code = 4'hA;
      7'b1100000: g.code = 4'hB;
      7'b0110001: g.code = 4'hC;
      7'b1000010: g.code = 4'hD;
      7'b0110000: g.code = 4'hE;
      7'b0111000: g.code = 4'hF;
      7'b1111111: g.blank = 1'b1;
      default:    g.err = 1'b1;
    endcase
    return g;
  endfunction

  state_t                  state, state_nxt;
  logic [7*NUM_DIGITS-1:0] s_cur, s_prev, last_frame;
  logic                    cur_ok, prev_ok, have_last;
  logic [CNT_W-1:0]        stab_cnt, stab_nxt;

  logic                    valid_q, overrun_q;
  logic [4*NUM_DIGITS-1:0] code_q;
  logic [NUM_DIGITS-1:0]   blank_q, err_q;

  logic                    changed, stable_hit, is_new;
  logic                    report, drop, accept;
  logic [4*NUM_DIGITS-1:0] dec_code;
  logic [NUM_DIGITS-1:0]   dec_blank, dec_err;
  glyph_t                  g;

  // s_prev only becomes meaningful two samples after reset, so until then every
  // sample counts as a change; this makes the first frame's latency independent of its value.
  always_comb begin
    changed    = !prev_ok || (s_cur != s_prev);
    stable_hit = !changed && (stab_cnt == STABLE_PRE);
    is_new     = !have_last || (s_cur != last_frame);
    if (changed)                      stab_nxt = '0;
    else if (stab_cnt != STABLE_MAX)  stab_nxt = stab_cnt + CNT_W'(1);
    else                              stab_nxt = stab_cnt;
  end

  always_comb begin
    dec_code  = '0;
    dec_blank = '0;
    dec_err   = '0;
    g         = '{code: 4'h0, blank: 1'b0, err: 1'b0};
    for (int d = 0; d < NUM_DIGITS; d++) begin
      g                = decode_glyph(s_cur[7*d +: 7]);
      dec_code[4*d +: 4] = g.code;
      dec_blank[d]     = g.blank;
      dec_err[d]       = g.err;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    report    = 1'b0;
    drop      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (changed) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (stable_hit) begin
          if (is_new) begin
            report    = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        drop = stable_hit && is_new;
        if (out_if.out_ready) begin
          accept = 1'b1;
          // Leaving HOLD while a frame is still counting up must keep watching it.
          state_nxt = (stab_nxt == STABLE_MAX) ? IDLE : SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_cur      <= '0;
      s_prev     <= '0;
      cur_ok     <= 1'b0;
      prev_ok    <= 1'b0;
      stab_cnt   <= '0;
      last_frame <= '0;
      have_last  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      code_q     <= '0;
      blank_q    <= '0;
      err_q      <= '0;
    end else begin
      state     <= state_nxt;
      s_cur     <= seg_in;
      s_prev    <= s_cur;
      cur_ok    <= 1'b1;
      prev_ok   <= cur_ok;
      stab_cnt  <= stab_nxt;
      overrun_q <= drop;
      if (report || drop) begin
        last_frame <= s_cur;
        have_last  <= 1'b1;
      end
      if (report) begin
        valid_q <= 1'b1;
        code_q  <= dec_code;
        blank_q <= dec_blank;
        err_q   <= dec_err;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_code  = code_q;
  assign out_if.out_blank = blank_q;
  assign out_if.out_err   = err_q;
  assign out_if.overrun   = overrun_q;

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (report && (|dec_err) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  // Without the error counter there is no extra state.
`endif

endmodule

// File: tb/tb_seg7_glyph_decoder.sv
// Bench for seg7_glyph_decoder: a run-length model of the sampled segment bus predicts
// every output each cycle; directed scenarios pin latency, overrun, blank/err and reset.
`timescale 1ns/1ps
module tb_seg7_glyph_decoder;
  localparam int ND = 3;
  localparam int SC = 4;
  localparam int FW = 7*ND;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] seg_in;

  seg7_glyph_decoder_if #(.NUM_DIGITS(ND)) bus ();

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seg7_glyph_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
`ifdef SEG7_DEC_ERRCNT_EN
    .err_count (err_count),
`endif
    .out_if    (bus.master)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [FW-1:0] mk(input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    return {d2, d1, d0};
  endfunction

  function automatic void model_decode(input logic [FW-1:0] f, output logic [4*ND-1:0] c,
                                       output logic [ND-1:0] b, output logic [ND-1:0] e);
    logic [6:0] p;
    bit         found;
    c = '0; b = '0; e = '0;
    for (int d = 0; d < ND; d++) begin
      p = f[7*d +: 7];
      if (p == 7'h7F) begin
        b[d] = 1'b1;
      end else begin
        found = 0;
        for (int k = 0; k < 16; k++)
          if (GLYPH[k] == p) begin c[4*d +: 4] = 4'(k); found = 1; end
        if (!found) e[d] = 1'b1;
      end
    end
  endfunction

  // Behavioural model: a frame is stable once SC+1 equal samples have been taken since
  // reset; it is reported if it differs from the last recorded frame, dropped if one is pending.
  bit            live = 0;
  int            run_len;
  logic [FW-1:0] run_val, last;
  bit            have_last;
  bit            m_valid, m_over;
  logic [4*ND-1:0] m_code;
  logic [ND-1:0] m_blank, m_err;
  int            m_errcnt;

  initial begin
    bit            hit, is_new, acc, in_rdy;
    logic [FW-1:0] in_seg;
    logic [4*ND-1:0] c;
    logic [ND-1:0] b, e;
    forever begin
      @(posedge clk);
      in_rdy = bus.out_ready;
      in_seg = seg_in;
      if (!rst_n) begin
        live = 1; run_len = 0; run_val = '0; last = '0; have_last = 0;
        m_valid = 0; m_over = 0; m_code = '0; m_blank = '0; m_err = '0; m_errcnt = 0;
      end else if (live) begin
        hit    = (run_len == SC + 1);
        acc    = m_valid && in_rdy;
        m_over = 0;
        if (hit) begin
          is_new = !have_last || (run_val != last);
          if (m_valid) begin
            if (is_new) begin m_over = 1; last = run_val; have_last = 1; end
          end else if (is_new) begin
            model_decode(run_val, c, b, e);
            m_valid = 1; m_code = c; m_blank = b; m_err = e;
            last = run_val; have_last = 1;
            if (|e && m_errcnt < 255) m_errcnt++;
          end
        end
        if (acc) m_valid = 0;
        if (run_len > 0 && in_seg == run_val) begin
          if (run_len < SC + 2) run_len++;
        end else begin
          run_val = in_seg; run_len = 1;
        end
      end
      #1;
      if (live) begin
        check("valid",   64'(bus.out_valid), 64'(m_valid));
        check("code",    64'(bus.out_code),  64'(m_code));
        check("blank",   64'(bus.out_blank), 64'(m_blank));
        check("err",     64'(bus.out_err),   64'(m_err));
        check("overrun", 64'(bus.overrun),   64'(m_over));
`ifdef SEG7_DEC_ERRCNT_EN
        check("err_count", 64'(err_count), 64'(m_errcnt));
`endif
      end
    end
  end

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) begin ok = 1; break; end
    end
  endtask

  // Releases/holds reset at a negedge and checks valid rises exactly SC+1 edges after the first sample.
  task automatic latency_check(input string tag, input logic [4*ND-1:0] exp_code);
    for (int i = 0; i <= SC + 1; i++) begin
      @(posedge clk); #2;
      if (i < SC + 1) check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
      else begin
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_code"},  64'(bus.out_code),  64'(exp_code));
      end
    end
  endtask

  initial begin
    bit            ok, frozen;
    int            cnt, ov;
    logic [4*ND-1:0] cap;
    logic [FW-1:0] pool [4];
    logic [6:0]    dg [ND];
    int            r;

    rst_n = 1'b0; seg_in = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Basic latency and single-cycle handshake: F8A
    rst_n = 1'b1;
    seg_in = mk(7'b0111000, 7'b0000000, 7'b0001000);
    latency_check("first", 12'hF8A);
    check("first_blank", 64'(bus.out_blank), 64'd0);
    check("first_err",   64'(bus.out_err),   64'd0);
    @(posedge clk); #2;
    check("first_single", 64'(bus.out_valid), 64'd0);

    // Same frame held: no re-report
    cnt = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); cnt += int'(bus.out_valid); end
    check("no_rereport", 64'(cnt), 64'd0);

    // Glitching digit 0 then settling at "1"
    cnt = 0; cap = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin cnt++; cap = bus.out_code; end
      if (i < 20) seg_in = mk(7'b0111000, 7'b0000000, ((i / 2) % 2 == 1) ? GLYPH[1] : GLYPH[2]);
    end
    check("glitch_reports", 64'(cnt), 64'd1);
    check("glitch_code",    64'(cap), 64'hF81);

    // Overrun: hold frame 012, second frame 345 settles while not ready
    @(negedge clk);
    bus.out_ready = 1'b0;
    seg_in = mk(GLYPH[0], GLYPH[1], GLYPH[2]);
    wait_valid(20, ok);
    check("ovr_first_seen", 64'(ok), 64'd1);
    check("ovr_first_code", 64'(bus.out_code), 64'h012);
    @(negedge clk);
    seg_in = mk(GLYPH[3], GLYPH[4], GLYPH[5]);
    ov = 0; frozen = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ov += int'(bus.overrun);
      if (!bus.out_valid || bus.out_code !== 12'h012) frozen = 0;
    end
    check("ovr_frozen", 64'(frozen), 64'd1);
    check("ovr_pulses", 64'(ov), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    check("ovr_accept", 64'(bus.out_valid), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); cnt += int'(bus.out_valid); end
    check("ovr_dropped", 64'(cnt), 64'd0);

    // Blank and unrecognised glyphs
`ifdef SEG7_DEC_ERRCNT_EN
    check("errcnt_before", 64'(err_count), 64'd0);
`endif
    @(negedge clk);
    seg_in = mk(7'b1111111, 7'b1010101, GLYPH[9]);
    wait_valid(20, ok);
    check("be_seen",  64'(ok), 64'd1);
    check("be_code",  64'(bus.out_code),  64'h009);
    check("be_blank", 64'(bus.out_blank), 64'b100);
    check("be_err",   64'(bus.out_err),   64'b010);
`ifdef SEG7_DEC_ERRCNT_EN
    check("errcnt_after", 64'(err_count), 64'd1);
`endif

    // Reset while holding, then the same frame is reported again
    @(negedge clk);
    bus.out_ready = 1'b0;
    seg_in = mk(GLYPH[5], GLYPH[6], GLYPH[7]);
    wait_valid(20, ok);
    check("rst_hold_seen", 64'(ok), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_code",  64'(bus.out_code),  64'd0);
    check("rst_flags", 64'({bus.out_blank, bus.out_err, bus.overrun}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    latency_check("rerep", 12'h567);

    // Randomised traffic against the model
    for (int p = 0; p < 4; p++) begin
      for (int d = 0; d < ND; d++) begin
        r = int'($urandom_range(0, 19));
        dg[d] = (r < 16) ? GLYPH[r] : (r < 18) ? 7'h7F : 7'($urandom);
      end
      pool[p] = mk(dg[2], dg[1], dg[0]);
    end
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 7) == 0) seg_in = FW'({$urandom, $urandom});
      else seg_in = pool[$urandom_range(0, 3)];
      r = int'($urandom_range(1, 12));
      for (int h = 0; h < r; h++) begin
        @(negedge clk);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        rst_n = ($urandom_range(0, 399) != 0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
